// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary-GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

  // Callers sign-extend into this width and truncate the magnitude back to NBits.
  localparam int ABS_W = 64;

  function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] x);
    if (x[ABS_W-1]) begin
      return ~x + 64'd1;
    end else begin
      return x;
    end
  endfunction

  function automatic int k_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One Stein iteration: consumes (a, b, k) and produces the next (a, b, k) or flags completion.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int NBits = 16,
  parameter int KW    = k_width(NBits)
) (
  input  logic [NBits-1:0] a,
  input  logic [NBits-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [NBits-1:0] a_nxt,
  output logic [NBits-1:0] b_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             done,
  output logic [NBits-1:0] result
);

  // Result is bounded by min(|x|,|y|), so restoring the common power of two cannot overflow.
  assign result = a << k;

  // Priority-ordered reduction step.
  always_comb begin
    a_nxt = a;
    b_nxt = b;
    k_nxt = k;
    done  = 1'b0;
    if (a == b) begin
      done = 1'b1;
    end else if (!a[0] && !b[0]) begin
      a_nxt = a >> 1'b1;
      b_nxt = b >> 1'b1;
      k_nxt = k + KW'(1);
    end else if (!a[0]) begin
      a_nxt = a >> 1'b1;
    end else if (!b[0]) begin
      b_nxt = b >> 1'b1;
    end else if (a > b) begin
      a_nxt = (a - b) >> 1'b1;
    end else begin
      b_nxt = (b - a) >> 1'b1;
    end
  end

endmodule

// File: rtl/gcd_core.sv
// Sequential GCD engine with a start/rdy level handshake; gcd with a zero operand is 0.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int NBits = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBits-1:0] xi,
  input  logic [NBits-1:0] yi,
  output logic [NBits-1:0] xo,
  output logic             rdy
);

  localparam int KW = k_width(NBits);

  gcd_state_t       state_r, state_nxt_s;
  logic [NBits-1:0] a_r, b_r, a_nxt_s, b_nxt_s;
  logic [KW-1:0]    k_r, k_nxt_s;
  logic [NBits-1:0] xo_r, xo_nxt_s;
  logic             rdy_r, rdy_nxt_s;
  logic [NBits-1:0] abs_x_s, abs_y_s;
  logic [NBits-1:0] step_a_s, step_b_s, step_res_s;
  logic [KW-1:0]    step_k_s;
  logic             step_done_s;

  assign abs_x_s = NBits'(abs_val({{(ABS_W-NBits){xi[NBits-1]}}, xi}));
  assign abs_y_s = NBits'(abs_val({{(ABS_W-NBits){yi[NBits-1]}}, yi}));

  gcd_step #(.NBits(NBits), .KW(KW)) u_step (
    .a      (a_r),
    .b      (b_r),
    .k      (k_r),
    .a_nxt  (step_a_s),
    .b_nxt  (step_b_s),
    .k_nxt  (step_k_s),
    .done   (step_done_s),
    .result (step_res_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-value logic for the operand and output registers.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    k_nxt_s     = k_r;
    xo_nxt_s    = xo_r;
    rdy_nxt_s   = rdy_r;
    case (state_r)
      IDLE: begin
        rdy_nxt_s = 1'b0;
        if (start) begin
          a_nxt_s = abs_x_s;
          b_nxt_s = abs_y_s;
          k_nxt_s = {KW{1'b0}};
          if ((abs_x_s == {NBits{1'b0}}) || (abs_y_s == {NBits{1'b0}})) begin
            xo_nxt_s    = {NBits{1'b0}};
            rdy_nxt_s   = 1'b1;
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (step_done_s) begin
          xo_nxt_s    = step_res_s;
          rdy_nxt_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          a_nxt_s = step_a_s;
          b_nxt_s = step_b_s;
          k_nxt_s = step_k_s;
        end
      end
      DONE: begin
        // Holding start high parks here so each operation gives a single rdy rise.
        if (start) begin
          state_nxt_s = DONE;
        end else begin
          rdy_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      default: begin
        rdy_nxt_s   = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {NBits{1'b0}};
      b_r   <= {NBits{1'b0}};
      k_r   <= {KW{1'b0}};
      xo_r  <= {NBits{1'b0}};
      rdy_r <= 1'b0;
    end else begin
      a_r   <= a_nxt_s;
      b_r   <= b_nxt_s;
      k_r   <= k_nxt_s;
      xo_r  <= xo_nxt_s;
      rdy_r <= rdy_nxt_s;
    end
  end

  assign xo  = xo_r;
  assign rdy = rdy_r;

endmodule

// File: tb/tb_gcd_core.sv
// Scoreboard bench for gcd_core: stimulus pushes brute-force expectations, a monitor checks each rdy rise.
module tb_gcd_core;

  localparam int N       = 16;
  localparam int LAT_MAX = 2 * N + 2;

  typedef struct {
    logic [N-1:0] val;
    int           start_cyc;
    int           bound;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] xi    = '0;
  logic [N-1:0] yi    = '0;
  logic [N-1:0] xo;
  logic         rdy;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  logic [N-1:0] last_res = '0;

  gcd_core #(.NBits(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .xi    (xi),
    .yi    (yi),
    .xo    (xo),
    .rdy   (rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_gcd(input int x, input int y);
    int ax, ay, m;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    if (ax == 0 || ay == 0) return 0;
    m = (ax < ay) ? ax : ay;
    for (int d = m; d >= 1; d--) begin
      if ((ax % d == 0) && (ay % d == 0)) return d;
    end
    return 1;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every rdy rise must match the oldest outstanding expectation, within its latency bound.
  initial begin : monitor
    logic prev_rdy;
    exp_t e;
    int   lat;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rdy = 1'b0;
      end else begin
        if (rdy === 1'b1 && prev_rdy === 1'b0) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_rdy: rdy rose with xo=%0d and no operation pending", xo);
          end else begin
            e = sb.pop_front();
            check("result", xo, e.val);
            lat = cyc - e.start_cyc;
            n_vec++;
            if (lat < 1 || lat > e.bound) begin
              n_err++;
              $display("FAIL latency: got %0d clocks, required 1..%0d", lat, e.bound);
            end
          end
        end
        prev_rdy = rdy;
      end
    end
  end

  task automatic run_op(input int x, input int y, input int bound, input bit hold);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    @(negedge clk);
    xi    = N'(x);
    yi    = N'(y);
    start = 1'b1;
    e.val       = N'(ref_gcd(x, y));
    e.start_cyc = cyc;
    e.bound     = bound;
    sb.push_back(e);
    last_res = e.val;
    for (int i = 0; i < LAT_MAX + 8 && !seen; i++) begin
      @(negedge clk);
      xi = N'($urandom);
      yi = N'($urandom);
      if (!hold) start = 1'b0;
      if (rdy === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: rdy not seen for x=%0d y=%0d, expected %0d", x, y, e.val);
      if (sb.size() > 0) sb.delete(sb.size() - 1);
    end
  endtask

  task automatic finish_op();
    start = 1'b0;
    @(negedge clk);
    check("rdy_fall", N'(rdy), N'(0));
    check("xo_retain", xo, last_res);
  endtask

  initial begin : stimulus
    int x, y;
    repeat (3) @(negedge clk);
    check("reset_rdy", N'(rdy), N'(0));
    check("reset_xo", xo, N'(0));
    rst = 1'b0;

    run_op(13, 7, LAT_MAX, 1'b1);    finish_op();
    run_op(620, 620, 3, 1'b1);       finish_op();
    run_op(0, 0, 2, 1'b1);           finish_op();
    run_op(0, 5, 2, 1'b1);           finish_op();
    run_op(9, 0, 2, 1'b1);           finish_op();
    run_op(42, 18, LAT_MAX, 1'b1);   finish_op();
    run_op(18, 42, LAT_MAX, 1'b1);   finish_op();
    run_op(-18, -42, LAT_MAX, 1'b1); finish_op();
    run_op(-(1 << (N - 1)), 4, LAT_MAX, 1'b1); finish_op();

    // start held high after completion: rdy and xo must stay put
    run_op(84, 36, LAT_MAX, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("hold_rdy", N'(rdy), N'(1));
      check("hold_xo", xo, last_res);
    end
    finish_op();

    // start dropped while calculating: operation still completes
    run_op(1071, 462, LAT_MAX, 1'b0); finish_op();

    for (int i = 0; i < 100; i++) begin
      x = $urandom_range((1 << (N - 1)) - 1, 1);
      y = $urandom_range((1 << (N - 1)) - 1, 1);
      run_op(x, y, LAT_MAX, (i % 2) == 0);
      finish_op();
    end

    // reset in the middle of a long calculation aborts it
    @(negedge clk);
    xi    = N'(32767);
    yi    = N'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rdy", N'(rdy), N'(0));
    check("abort_xo", xo, N'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_rdy", N'(rdy), N'(0));

    run_op(48, 180, LAT_MAX, 1'b1); finish_op();

    repeat (4) @(negedge clk);
    check("sb_empty", N'(sb.size()), N'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
